// File: rtl/vga_fill_engine_if.sv
// Command and pixel-port bundle between game/demo logic and the fill engine.
// The master issues fill commands; the slave (engine) drives the VGA write port.
interface vga_fill_engine_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_clear;
  logic [7:0] cmd_x;
  logic [6:0] cmd_y;
  logic [7:0] cmd_w;
  logic [6:0] cmd_h;
  logic [2:0] cmd_color;
  logic       abort;
  logic [7:0] VGA_X;
  logic [6:0] VGA_Y;
  logic [2:0] VGA_COLOR;
  logic       plot;
  logic       done;

  modport master (
    output cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, abort,
    input  cmd_ready, VGA_X, VGA_Y, VGA_COLOR, plot, done
  );

  modport slave (
    input  cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, abort,
    output cmd_ready, VGA_X, VGA_Y, VGA_COLOR, plot, done
  );
endinterface

// File: rtl/vga_fill_engine.sv
// Rectangle / full-screen fill sequencer for the VGA pixel-write port.
// Emits one clipped pixel per clock in raster order, x fastest.
module vga_fill_engine #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input logic              CLOCK_50,
  input logic              reset,
  vga_fill_engine_if.slave bus
);
  localparam logic [8:0] X_LAST = 9'(SCREEN_W - 1);
  localparam logic [7:0] Y_LAST = 8'(SCREEN_H - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t     state_reg, state_next;
  logic [7:0] x_reg, x_next, x0_reg, x0_next, xe_reg, xe_next;
  logic [6:0] y_reg, y_next, y0_reg, y0_next, ye_reg, ye_next;
  logic [2:0] color_reg, color_next;
  logic       plot_reg, plot_next;
  logic [8:0] x_sum;
  logic [7:0] y_sum;
  logic       cmd_empty;

  // One extra bit of headroom so far corners never wrap before clipping.
  assign x_sum = {1'b0, bus.cmd_x} + {1'b0, bus.cmd_w} - 9'd1;
  assign y_sum = {1'b0, bus.cmd_y} + {1'b0, bus.cmd_h} - 8'd1;
  assign cmd_empty = (bus.cmd_w == 8'd0) || (bus.cmd_h == 7'd0) ||
                     ({1'b0, bus.cmd_x} > X_LAST) || ({1'b0, bus.cmd_y} > Y_LAST);

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      x0_reg    <= '0;
      y0_reg    <= '0;
      xe_reg    <= '0;
      ye_reg    <= '0;
      color_reg <= '0;
      plot_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      x_reg     <= x_next;
      y_reg     <= y_next;
      x0_reg    <= x0_next;
      y0_reg    <= y0_next;
      xe_reg    <= xe_next;
      ye_reg    <= ye_next;
      color_reg <= color_next;
      plot_reg  <= plot_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    x0_next    = x0_reg;
    y0_next    = y0_reg;
    xe_next    = xe_reg;
    ye_next    = ye_reg;
    color_next = color_reg;
    plot_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (bus.cmd_clear) begin
            x0_next    = '0;
            y0_next    = '0;
            xe_next    = X_LAST[7:0];
            ye_next    = Y_LAST[6:0];
            x_next     = '0;
            y_next     = '0;
            color_next = bus.cmd_color;
            plot_next  = 1'b1;
            state_next = FILL;
          end else if (cmd_empty) begin
            state_next = DONE;
          end else begin
            x0_next    = bus.cmd_x;
            y0_next    = bus.cmd_y;
            xe_next    = (x_sum > X_LAST) ? X_LAST[7:0] : x_sum[7:0];
            ye_next    = (y_sum > Y_LAST) ? Y_LAST[6:0] : y_sum[6:0];
            x_next     = bus.cmd_x;
            y_next     = bus.cmd_y;
            color_next = bus.cmd_color;
            plot_next  = 1'b1;
            state_next = FILL;
          end
        end
      end
      FILL: begin
        // Last-pixel completion wins over abort so only one done is produced.
        if (x_reg == xe_reg && y_reg == ye_reg) begin
          x_next     = x0_reg;
          state_next = DONE;
        end else if (bus.abort) begin
          state_next = DONE;
        end else if (x_reg == xe_reg) begin
          x_next    = x0_reg;
          y_next    = y_reg + 7'd1;
          plot_next = 1'b1;
        end else begin
          x_next    = x_reg + 8'd1;
          plot_next = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign bus.cmd_ready = (state_reg == IDLE);
  assign bus.done      = (state_reg == DONE);
  assign bus.VGA_X     = x_reg;
  assign bus.VGA_Y     = y_reg;
  assign bus.VGA_COLOR = color_reg;
  assign bus.plot      = plot_reg;
endmodule

// File: doc/vga_fill_engine.md
# vga_fill_engine

Command-driven controller that sequences the VGA pixel-write port (`VGA_X`, `VGA_Y`, `VGA_COLOR`, `plot`) to fill solid rectangles or clear the whole 160x120 screen. It plots one pixel per `CLOCK_50` cycle in raster order and clips to the screen. It sits between demo/game logic and the VGA adapter, replacing hand-written x/y sweep counters in each design.

## Interface
- `SCREEN_W`, 160, visible columns; x range 0..SCREEN_W-1.
- `SCREEN_H`, 120, visible rows; y range 0..SCREEN_H-1.

- `CLOCK_50` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-high; forces all state to reset values immediately.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: engine can accept a command; high only in IDLE.
- `cmd_clear` in 1: 1 means a full-screen fill; `cmd_x`/`cmd_y`/`cmd_w`/`cmd_h` are ignored.
- `cmd_x` in 8, `cmd_y` in 7: top-left corner.
- `cmd_w` in 8, `cmd_h` in 7: width and height in pixels; 0 means empty.
- `cmd_color` in 3: fill colour (0-7).
- `abort` in 1: synchronous stop of the current fill.
- `VGA_X` out 8, `VGA_Y` out 7, `VGA_COLOR` out 3: pixel address and colour, registered.
- `plot` out 1: pixel is written this cycle; registered.
- `done` out 1: one-cycle pulse when a command completes or is aborted.

## Operation
- States: IDLE, FILL, DONE. `cmd_ready` = (state == IDLE), combinational.
- **Accept:** `cmd_valid && cmd_ready` on an edge. Latch the colour and bounds:
  - Clear command: x0=0, y0=0, xe=SCREEN_W-1, ye=SCREEN_H-1.
  - Otherwise: x0=cmd_x, y0=cmd_y, xe=min(cmd_x+cmd_w-1, SCREEN_W-1), ye=min(cmd_y+cmd_h-1, SCREEN_H-1). Compute in 9-bit (x) and 8-bit (y) arithmetic, so there is no wrap.
  - Empty command: `cmd_w`==0, `cmd_h`==0, `cmd_x`>=SCREEN_W, or `cmd_y`>=SCREEN_H (non-clear only). Go IDLE->DONE and plot nothing.
  - Non-empty command: go IDLE->FILL with VGA_X=x0, VGA_Y=y0, VGA_COLOR=colour, plot=1.
- **FILL:** each cycle emits one pixel; x advances fastest.
  - If VGA_X==xe: VGA_X<=x0. Then, if VGA_Y==ye, set plot<=0 and go to DONE; else VGA_Y<=VGA_Y+1.
  - Otherwise VGA_X<=VGA_X+1.
- **abort** in FILL: the pixel currently presented is still written. Next edge: plot<=0, go to DONE. `abort` is ignored in IDLE and DONE.
- **DONE:** done=1 for exactly one cycle, plot=0, then go to IDLE.
- `cmd_*` inputs are ignored outside IDLE; no queuing.
- In IDLE and DONE, VGA_X, VGA_Y and VGA_COLOR hold their last values and plot=0.

## Timing
- Reset values: state IDLE, VGA_X=0, VGA_Y=0, VGA_COLOR=0, plot=0, done=0, cmd_ready=1.
- Command accepted at edge k:
  - First plot is high in cycle k+1.
  - A clipped rectangle of W'xH' pixels plots in W'·H' consecutive cycles with no gaps.
  - done is high in the cycle after the last plot; cmd_ready returns the cycle after that.
- Empty command accepted at edge k: done in cycle k+1, cmd_ready in cycle k+2, plot never high.
- Full clear: 19200 plot cycles; last pixel is (159,119).
- Back-to-back commands: minimum 2 cycles without plot between fills (DONE, then IDLE accept).
- Reset asserted mid-FILL: plot drops to 0 asynchronously and no done is issued. After release, the first valid command accepted in IDLE is honoured.
- abort and the last pixel in the same cycle: normal completion, with a single done pulse.

## Test plan
- Reset: assert reset mid-clock -> all outputs at reset values immediately, cmd_ready=1; no plot in 10 following idle cycles.
- Rectangle x=10, y=5, w=2, h=2, colour 3 -> plots (10,5),(11,5),(10,6),(11,6) in 4 consecutive cycles, all with colour 3. done in the next cycle; cmd_ready high one cycle later.
- Clipping x=158, y=119, w=5, h=3, colour 6 -> exactly 2 plots, (158,119) and (159,119), then done.
- Empty cases: w=0; h=0; x=160; y=120 -> each gives zero plot cycles and done exactly 1 cycle after accept.
- Clear, colour 1 -> 19200 plots, first (0,0), row wrap (159,0)->(0,1), last (159,119), one done. cmd_valid pulses during the fill are not accepted.
- Abort after the 5th pixel of a 10x10 fill -> exactly 5 plots then done. Separately, reset after the 5th pixel -> plot low immediately, no done, and the next command fills normally.
